pcileech_actv_resp_tx: RTL and testbench

Transmit-side counterpart of the activation-code detector. It receives one-cycle event pulses (activate, deactivate, interrupt-enable) decoded from host words and returns a 4-word acknowledge frame to the host. The frame is merged into the 32-bit FPGA→FT601 data stream only between upstream packets, so normal TLP/config traffic is never split. It sits between the FIFO controller's outbound 32-bit stream and the COM transmit path, in the `clk` domain.

---
 rtl/pcileech_actv_resp_tx.sv | 178 +++++++++++++++++
 tb/tb_pcileech_actv_resp_tx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_actv_resp_tx.sv
// Acknowledge-frame transmitter merged into the FPGA->FT601 word stream.
// Ports: clk/rst; evt_act/evt_deact/evt_int event pulses;
//   up_data/up_valid/up_last/up_ready upstream stream;
//   tx_data/tx_valid/tx_ready COM-side stream;
//   activated/int_en/seq status.
module pcileech_actv_resp_tx #(
  parameter logic [31:0] RESP_MAGIC    = 32'h66665A5A,
  parameter logic        ACT_RESET_VAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        evt_act,
  input  logic        evt_deact,
  input  logic        evt_int,
  input  logic [31:0] up_data,
  input  logic        up_valid,
  input  logic        up_last,
  output logic        up_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        activated,
  output logic        int_en,
  output logic [7:0]  seq
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        pend_act;
  logic        pend_deact;
  logic        pend_int;
  logic        any_pend;
  logic [1:0]  idx;
  logic [1:0]  idx_nx;
  logic [31:0] w1_r;
  logic [31:0] word_nx;
  logic [31:0] tx_data_r;
  logic        tx_valid_r;
  logic [7:0]  code_sel;
  logic        act_nx;
  logic        int_nx;
  logic        xfer;
  logic        resp_enter;
  logic        resp_done;

  // Status as it will read after this cycle's events;
  // the frame latched on entry reports this view.
  always_comb begin
    act_nx = activated;
    if (evt_deact) begin
      act_nx = 1'b0;
    end else if (evt_act) begin
      act_nx = 1'b1;
    end
    int_nx = int_en | evt_int;
  end

  always_comb begin
    any_pend = pend_act | pend_deact | pend_int;
    code_sel = 8'h03;
    priority case (1'b1)
      pend_deact: code_sel = 8'h02;
      pend_act:   code_sel = 8'h01;
      default:    code_sel = 8'h03;
    endcase
  end

  always_comb begin
    idx_nx  = idx + 2'd1;
    word_nx = RESP_MAGIC;
    unique case (idx_nx)
      2'd1:    word_nx = w1_r;
      2'd2:    word_nx = ~RESP_MAGIC;
      2'd3:    word_nx = RESP_MAGIC ^ w1_r ^ ~RESP_MAGIC;
      default: word_nx = RESP_MAGIC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    up_ready = 1'b0;
    tx_valid = tx_valid_r;
    tx_data  = tx_data_r;
    unique case (state)
      IDLE: begin
        if (any_pend) begin
          state_nx = RESP;
        end else if (up_valid) begin
          state_nx = PASS;
        end
      end
      PASS: begin
        up_ready = tx_ready;
        tx_valid = up_valid;
        tx_data  = up_data;
        if (up_valid && tx_ready && up_last) begin
          state_nx = IDLE;
        end
      end
      RESP: begin
        if (tx_valid_r && tx_ready && idx == 2'd3) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign xfer       = tx_valid_r & tx_ready;
  assign resp_enter = (state == IDLE) & any_pend;
  assign resp_done  = (state == RESP) & xfer
                    & (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      activated  <= ACT_RESET_VAL;
      int_en     <= 1'b0;
      seq        <= 8'h00;
      pend_act   <= 1'b0;
      pend_deact <= 1'b0;
      pend_int   <= 1'b0;
      idx        <= 2'd0;
      w1_r       <= 32'h0;
      tx_data_r  <= 32'h0;
      tx_valid_r <= 1'b0;
    end else begin
      activated <= act_nx;
      int_en    <= int_nx;

      // Clear first so a same-cycle event re-arms its flag.
      if (resp_enter) begin
        priority case (1'b1)
          pend_deact: pend_deact <= 1'b0;
          pend_act:   pend_act   <= 1'b0;
          default:    pend_int   <= 1'b0;
        endcase
      end
      if (evt_deact) begin
        pend_deact <= 1'b1;
      end else if (evt_act) begin
        pend_act <= 1'b1;
      end
      if (evt_int) begin
        pend_int <= 1'b1;
      end

      if (resp_enter) begin
        w1_r       <= {code_sel, seq, 14'h0,
                       int_nx, act_nx};
        tx_data_r  <= RESP_MAGIC;
        tx_valid_r <= 1'b1;
        idx        <= 2'd0;
      end else if (resp_done) begin
        tx_valid_r <= 1'b0;
        idx        <= 2'd0;
        seq        <= seq + 8'd1;
      end else if (state == RESP && xfer) begin
        idx       <= idx_nx;
        tx_data_r <= word_nx;
      end
    end
  end

endmodule

// File: tb/tb_pcileech_actv_resp_tx.sv
// Bench for pcileech_actv_resp_tx: frame table, hand sequences,
// and random events/packets against a transaction-level model.
module tb_pcileech_actv_resp_tx;

  localparam logic [31:0] MAGIC = 32'h66665A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        evt_act = 1'b0;
  logic        evt_deact = 1'b0;
  logic        evt_int = 1'b0;
  logic [31:0] up_data = 32'h0;
  logic        up_valid = 1'b0;
  logic        up_last = 1'b0;
  logic        up_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        activated;
  logic        int_en;
  logic [7:0]  seq;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  logic [31:0] gotd[$];
  int          gotc[$];
  logic [31:0] expq[$];

  logic        mon_en = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic        rdy_fix = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = 32'h0;

  typedef struct {
    logic [2:0]  m;
    int          nfr;
    logic [31:0] w1a;
    logic [31:0] w1b;
    logic        act;
    logic        ie;
    logic [7:0]  sq;
  } vec_t;

  vec_t vt[7];

  pcileech_actv_resp_tx dut (
    .clk       (clk),
    .rst       (rst),
    .evt_act   (evt_act),
    .evt_deact (evt_deact),
    .evt_int   (evt_int),
    .up_data   (up_data),
    .up_valid  (up_valid),
    .up_last   (up_last),
    .up_ready  (up_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .activated (activated),
    .int_en    (int_en),
    .seq       (seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    tx_ready = rnd_rdy ? 1'($urandom_range(0, 1))
                       : rdy_fix;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && tx_valid)
        chk("stall_hold", tx_data, prev_d);
      if (tx_valid && tx_ready) begin
        gotd.push_back(tx_data);
        gotc.push_back(cyc);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data;
    end
  end

  function automatic void push_frame(input logic [31:0] w1);
    expq.push_back(MAGIC);
    expq.push_back(w1);
    expq.push_back(~MAGIC);
    expq.push_back(MAGIC ^ w1 ^ ~MAGIC);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gotd.delete();
    gotc.delete();
    expq.delete();
  endtask

  task automatic pulse(input logic [2:0] m, output int t);
    evt_act   = m[0];
    evt_deact = m[1];
    evt_int   = m[2];
    t = cyc;
    step();
    evt_act   = 1'b0;
    evt_deact = 1'b0;
    evt_int   = 1'b0;
  endtask

  task automatic wait_n;
    int b = 0;
    while (gotd.size() < expq.size() && b < 400) begin
      step();
      b++;
    end
    repeat (4) step();
  endtask

  task automatic cmp_q(input string nm);
    chk({nm, "_count"}, 32'(gotd.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (i < gotd.size())
        chk(nm, gotd[i], expq[i]);
    gotd.delete();
    gotc.delete();
    expq.delete();
  endtask

  task automatic send_pkt(input int len, input int ev_at,
                          input logic [2:0] ev_m);
    for (int i = 0; i < len; i++) begin
      automatic logic [31:0] d = $urandom;
      automatic logic acc = 1'b0;
      automatic int b = 0;
      up_data  = d;
      up_valid = 1'b1;
      up_last  = (i == len - 1);
      if (i == ev_at) begin
        evt_act   = ev_m[0];
        evt_deact = ev_m[1];
        evt_int   = ev_m[2];
      end
      expq.push_back(d);
      do begin
        @(negedge clk);
        acc = up_ready;
        step();
        evt_act   = 1'b0;
        evt_deact = 1'b0;
        evt_int   = 1'b0;
        b++;
      end while (!acc && b < 300);
      if (!acc) chk("pkt_accept", 32'd0, 32'd1);
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t0;
    logic        m_act;
    logic        m_ie;
    logic [7:0]  m_seq;

    vt[0] = '{3'b001, 1, 32'h01000001, 32'h0, 1'b1, 1'b0, 8'd1};
    vt[1] = '{3'b010, 1, 32'h02000000, 32'h0, 1'b0, 1'b0, 8'd1};
    vt[2] = '{3'b100, 1, 32'h03000003, 32'h0, 1'b1, 1'b1, 8'd1};
    vt[3] = '{3'b011, 1, 32'h02000000, 32'h0, 1'b0, 1'b0, 8'd1};
    vt[4] = '{3'b110, 2, 32'h02000002, 32'h03010002,
              1'b0, 1'b1, 8'd2};
    vt[5] = '{3'b101, 2, 32'h01000003, 32'h03010003,
              1'b1, 1'b1, 8'd2};
    vt[6] = '{3'b111, 2, 32'h02000002, 32'h03010002,
              1'b0, 1'b1, 8'd2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd0);
    chk("rst_activated", 32'(activated), 32'd1);
    chk("rst_int_en", 32'(int_en), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    do_reset();
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      pulse(vt[v].m, t);
      push_frame(vt[v].w1a);
      if (vt[v].nfr == 2) push_frame(vt[v].w1b);
      wait_n();
      if (gotc.size() >= 4) begin
        chk("lat_w0", 32'(gotc[0]), 32'(t + 2));
        for (int j = 1; j < 4; j++)
          chk("frame_contig", 32'(gotc[j]), 32'(gotc[0] + j));
      end
      if (vt[v].nfr == 2 && gotc.size() >= 5)
        chk("frame_gap", 32'(gotc[4]), 32'(gotc[3] + 2));
      cmp_q("tbl_word");
      chk("tbl_activated", 32'(activated), 32'(vt[v].act));
      chk("tbl_int_en", 32'(int_en), 32'(vt[v].ie));
      chk("tbl_seq", 32'(seq), 32'(vt[v].sq));
    end

    do_reset();
    pulse(3'b001, t0);
    step();
    pulse(3'b010, t);
    step();
    pulse(3'b100, t);
    push_frame(32'h01000001);
    push_frame(32'h02010002);
    push_frame(32'h03020002);
    wait_n();
    cmp_q("order_word");
    chk("order_activated", 32'(activated), 32'd0);
    chk("order_int_en", 32'(int_en), 32'd1);

    do_reset();
    send_pkt(5, 2, 3'b100);
    push_frame(32'h03000003);
    wait_n();
    if (gotc.size() >= 6) begin
      for (int j = 1; j < 5; j++)
        chk("pkt_contig", 32'(gotc[j]), 32'(gotc[0] + j));
      chk("pkt_to_frame", 32'(gotc[5]), 32'(gotc[4] + 2));
    end
    cmp_q("midpkt_word");

    do_reset();
    for (int i = 0; i < 256; i++) begin
      pulse(3'b100, t);
      push_frame({8'h03, 8'(i), 14'h0, 2'b11});
      wait_n();
      if (gotd.size() > 1)
        chk("seq_field", {24'h0, gotd[1][23:16]}, 32'(i));
      cmp_q("wrap_word");
    end
    chk("seq_wrap", 32'(seq), 32'd0);

    pulse(3'b100, t);
    push_frame(32'h03000003);
    wait_n();
    cmp_q("pre_rst_word");
    pulse(3'b010, t);
    step();
    step();
    chk("rst_mid_w1", tx_data, 32'h02010002);
    rst = 1'b1;
    step();
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_seq", 32'(seq), 32'd0);
    chk("abort_activated", 32'(activated), 32'd1);
    rst = 1'b0;
    gotd.delete();
    gotc.delete();
    expq.delete();
    repeat (8) step();
    chk("abort_no_words", 32'(gotd.size()), 32'd0);

    do_reset();
    m_act = 1'b1;
    m_ie  = 1'b0;
    m_seq = 8'd0;
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        send_pkt(int'($urandom_range(1, 4)), -1, 3'b000);
      end else begin
        automatic logic [2:0] m = 3'($urandom_range(1, 7));
        pulse(m, t);
        if (m[1]) m_act = 1'b0;
        else if (m[0]) m_act = 1'b1;
        if (m[2]) m_ie = 1'b1;
        if (m[1] || m[0]) begin
          push_frame({(m[1] ? 8'h02 : 8'h01), m_seq,
                      14'h0, m_ie, m_act});
          m_seq = m_seq + 8'd1;
        end
        if (m[2]) begin
          push_frame({8'h03, m_seq, 14'h0, m_ie, m_act});
          m_seq = m_seq + 8'd1;
        end
      end
      wait_n();
      cmp_q("rnd_word");
      chk("rnd_activated", 32'(activated), 32'(m_act));
      chk("rnd_int_en", 32'(int_en), 32'(m_ie));
      chk("rnd_seq", 32'(seq), 32'(m_seq));
    end
    rnd_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
